// File: rtl/datamem_resp.sv
// Data-memory responder: one word load/store per req/ready handshake,
// completed after WAIT wait states with a one-cycle ack and an address error flag.
module datamem_resp #(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        writeMem,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic        ready,
  output logic        ack,
  output logic [31:0] data,
  output logic        err
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  generate
    if (WAIT < 0 || WAIT > 15) begin : g_bad_wait
      $error("datamem_resp: WAIT must be in 0..15");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        data_q, data_d;
  logic               err_q, err_d;

  logic [31:0]        mem [DEPTH];

  logic               enter_resp;
  logic               acc_we;
  logic [31:0]        acc_addr;
  logic [31:0]        acc_wdata;
  logic               acc_err;
  logic [ADDR_W-1:0]  acc_idx;
  logic               mem_we;

  // Next-state, request latch and wait counter
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = writeMem;
          addr_d  = addr;
          wdata_d = writeData;
          cnt_d   = CNT_W'(WAIT);
          if (WAIT == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With WAIT=0 the access happens on the accept edge, so use the live inputs then
  always_comb begin
    acc_we    = (state_q == S_IDLE) ? writeMem  : we_q;
    acc_addr  = (state_q == S_IDLE) ? addr      : addr_q;
    acc_wdata = (state_q == S_IDLE) ? writeData : wdata_q;
    acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_W + 2)) != 32'h0);
    acc_idx   = acc_addr[ADDR_W+1:2];
    mem_we    = enter_resp && acc_we && !acc_err && !rst;
    data_d    = data_q;
    if (enter_resp && !acc_we) begin
      data_d = acc_err ? 32'h0 : mem[acc_idx];
    end
    err_d = enter_resp && acc_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Storage array is intentionally not reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign ack   = (state_q == S_RESP);
  assign data  = data_q;
  assign err   = err_q;

endmodule

// File: tb/tb_datamem_resp.sv
// Directed bench for datamem_resp: vector table on a WAIT=2 instance plus
// reset-abort and held-request sequences (the latter on a WAIT=0 instance).
module tb_datamem_resp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req, wm, ready, ack, err;
  logic [31:0] addr, wd, data;
  logic        req0, wm0, ready0, ack0, err0;
  logic [31:0] addr0, wd0, data0;

  datamem_resp #(.ADDR_W(8), .WAIT(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(req), .writeMem(wm), .addr(addr),
    .writeData(wd), .ready(ready), .ack(ack), .data(data), .err(err)
  );

  datamem_resp #(.ADDR_W(8), .WAIT(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .writeMem(wm0), .addr(addr0),
    .writeData(wd0), .ready(ready0), .ack(ack0), .data(data0), .err(err0)
  );

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the WAIT=2 instance; inputs are scrambled after accept
  task automatic do_txn(input vec_t v, input int idx);
    int n;
    chk($sformatf("v%0d ready_before", idx), 32'(ready), 32'd1);
    req = 1'b1; wm = v.we; addr = v.a; wd = v.wd;
    step();
    req = 1'b0; wm = ~v.we; addr = 32'h10; wd = 32'hFFFF_FFFF;
    chk($sformatf("v%0d ready_busy", idx), 32'(ready), 32'd0);
    n = 0;
    while (!ack && n < 10) begin
      step();
      n++;
    end
    chk($sformatf("v%0d latency", idx), 32'(n), 32'd2);
    chk($sformatf("v%0d err", idx), 32'(err), 32'(v.exp_err));
    chk($sformatf("v%0d data", idx), data, v.exp_data);
    step();
    chk($sformatf("v%0d ack_drop", idx), {30'd0, ack, err}, 32'd0);
    chk($sformatf("v%0d ready_after", idx), 32'(ready), 32'd1);
    chk($sformatf("v%0d data_held", idx), data, v.exp_data);
  endtask

  initial begin
    int saw_ack;
    vec_t v;
    vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vt[2]  = '{1'b1, 32'h0000_0011, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF};
    vt[3]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vt[4]  = '{1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0000_0000};
    vt[5]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'h0000_0000};
    vt[6]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'hCAFE_F00D};
    vt[7]  = '{1'b1, 32'h8000_0000, 32'h1111_1111, 1'b1, 32'hCAFE_F00D};
    vt[8]  = '{1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 1'b0, 32'hCAFE_F00D};
    vt[9]  = '{1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'hA5A5_A5A5};
    vt[10] = '{1'b0, 32'h0000_0002, 32'h0,         1'b1, 32'h0000_0000};
    vt[11] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};

    rst = 1'b1;
    req = 1'b0; wm = 1'b0; addr = '0; wd = '0;
    req0 = 1'b0; wm0 = 1'b0; addr0 = '0; wd0 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", {31'd0, ready}, 32'd1);
    chk("reset ack_err", {30'd0, ack, err}, 32'd0);
    chk("reset data", data, 32'h0);
    chk("reset0 outputs", {29'd0, ready0, ack0, err0}, 32'd4);
    rst = 1'b0;
    step();

    for (int i = 0; i < 12; i++) do_txn(vt[i], i);

    // Reset one cycle after accepting a store: no ack, store lost
    req = 1'b1; wm = 1'b1; addr = 32'h20; wd = 32'h5A5A_5A5A;
    step();
    req = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    chk("midrst ready", 32'(ready), 32'd1);
    chk("midrst ack_err", {30'd0, ack, err}, 32'd0);
    chk("midrst data", data, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    saw_ack = 0;
    repeat (6) begin
      step();
      if (ack) saw_ack = 1;
    end
    chk("midrst no_ack", 32'(saw_ack), 32'd0);
    v = '{1'b0, 32'h20, 32'h0, 1'b0, 32'hA5A5_A5A5};
    do_txn(v, 12);

    // WAIT=0: store, then req held for four back-to-back loads
    req0 = 1'b1; wm0 = 1'b1; addr0 = 32'h8; wd0 = 32'h0BAD_CAFE;
    step();
    chk("b2b store ack", {30'd0, ack0, err0}, 32'd2);
    chk("b2b store ready", 32'(ready0), 32'd0);
    wm0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("b2b c%0d ready_ack", i), {30'd0, ready0, ack0},
          (i % 2 == 0) ? 32'd2 : 32'd1);
      if (i % 2 == 1) chk($sformatf("b2b c%0d data", i), data0, 32'h0BAD_CAFE);
    end
    req0 = 1'b0;
    step();
    chk("b2b idle", {30'd0, ready0, ack0}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
